// File: rtl/ysyx_22041752_mul_ctrl_pkg.sv
// ysyx_22041752_mul_ctrl_pkg: op codes, FSM encodings and decode helpers for the multiplier sequencer
package ysyx_22041752_mul_ctrl_pkg;
  localparam int MUL_XLEN = 64;
  localparam logic [2:0] MUL_OP_MUL = 3'd0;
  localparam logic [2:0] MUL_OP_MULH = 3'd1;
  localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
  localparam logic [2:0] MUL_OP_MULHU = 3'd3;
  localparam logic [2:0] MUL_OP_MULW = 3'd4;
  localparam logic [1:0] MULC_IDLE = 2'd0;
  localparam logic [1:0] MULC_BUSY = 2'd1;
  localparam logic [1:0] MULC_DONE = 2'd2;
  typedef struct packed {
    logic w;
    logic h;
    logic su;
    logic u;
  } mode_t;
  // reserved codes 5-7 decode to all-zero, which is plain MUL
  function automatic mode_t op_mode(input logic [2:0] op);
    mode_t m;
    m.w = op == MUL_OP_MULW;
    m.h = op == MUL_OP_MULH || op == MUL_OP_MULHSU || op == MUL_OP_MULHU;
    m.su = op == MUL_OP_MULHSU;
    m.u = op == MUL_OP_MULHU;
    return m;
  endfunction
  function automatic logic [MUL_XLEN-1:0] sext32(input logic [MUL_XLEN-1:0] v);
    return {{(MUL_XLEN-32){v[31]}}, v[31:0]};
  endfunction
endpackage

// File: rtl/ysyx_22041752_mul_ctrl_if.sv
// ysyx_22041752_mul_ctrl_if: op request, result and multiplier-side signals of the multiplier sequencer
// slave modport is the sequencer; master modport is the EX-stage environment (issuer, consumer, multiplier)
interface ysyx_22041752_mul_ctrl_if;
  import ysyx_22041752_mul_ctrl_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [2:0] in_op;
  logic [MUL_XLEN-1:0] in_src1;
  logic [MUL_XLEN-1:0] in_src2;
  logic out_valid;
  logic out_ready;
  logic [MUL_XLEN-1:0] out_result;
  logic mul_valid;
  logic mul_u;
  logic mul_su;
  logic mul_h;
  logic [MUL_XLEN-1:0] mul_multiplicand;
  logic [MUL_XLEN-1:0] mul_multiplier;
  logic [MUL_XLEN-1:0] mul_product;
  logic mul_out_valid;
  modport slave (
    input flush, in_valid, in_op, in_src1, in_src2, out_ready, mul_product, mul_out_valid,
    output in_ready, out_valid, out_result, mul_valid, mul_u, mul_su, mul_h, mul_multiplicand, mul_multiplier
  );
  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready, mul_product, mul_out_valid,
    input in_ready, out_valid, out_result, mul_valid, mul_u, mul_su, mul_h, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/ysyx_22041752_mul_rcache.sv
// ysyx_22041752_mul_rcache: one-entry last-result cache keyed by {op, src1, src2}
// lk_*: combinational lookup of a key; wr_*: registered write that also sets the valid bit
module ysyx_22041752_mul_rcache #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      lk_op_i,
  input  logic [XLEN-1:0] lk_src1_i,
  input  logic [XLEN-1:0] lk_src2_i,
  output logic            lk_hit_o,
  output logic [XLEN-1:0] lk_data_o,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_op_i,
  input  logic [XLEN-1:0] wr_src1_i,
  input  logic [XLEN-1:0] wr_src2_i,
  input  logic [XLEN-1:0] wr_data_i
);
  logic vld_q;
  logic [2:0] op_q;
  logic [XLEN-1:0] src1_q, src2_q, data_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      op_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      data_q <= '0;
    end else if (wr_en_i) begin
      vld_q <= 1'b1;
      op_q <= wr_op_i;
      src1_q <= wr_src1_i;
      src2_q <= wr_src2_i;
      data_q <= wr_data_i;
    end
  end
  assign lk_hit_o = vld_q && {lk_op_i, lk_src1_i, lk_src2_i} == {op_q, src1_q, src2_q};
  assign lk_data_o = data_q;
endmodule

// File: rtl/ysyx_22041752_mul_ctrl.sv
// ysyx_22041752_mul_ctrl: EX-stage sequencer for the shared iterative RV64M multiplier
// clk, reset (async, active high); bus: op request/accept, result/consume, multiplier drive/return, flush
module ysyx_22041752_mul_ctrl
  import ysyx_22041752_mul_ctrl_pkg::*;
#(
  parameter int XLEN = MUL_XLEN,
  parameter bit CACHE_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  ysyx_22041752_mul_ctrl_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [2:0] op_q;
  logic [XLEN-1:0] src1_q, src2_q, res_q, res_d, lk_data, product;
  mode_t mode;
  logic accept, done, lk_hit, hit;
  assign mode = op_mode(op_q);
  assign accept = state_q == MULC_IDLE && bus.in_valid && !bus.flush;
  // a completion coinciding with flush is dropped, so it neither updates the result nor the cache
  assign done = state_q == MULC_BUSY && bus.mul_out_valid && !bus.flush;
  assign hit = CACHE_EN && lk_hit;
  assign product = mode.w ? sext32(bus.mul_product) : bus.mul_product;
  assign state_d = bus.flush ? MULC_IDLE
                 : accept ? (hit ? MULC_DONE : MULC_BUSY)
                 : done ? MULC_DONE
                 : (state_q == MULC_DONE && bus.out_ready) ? MULC_IDLE
                 : state_q;
  assign res_d = (accept && hit) ? lk_data : done ? product : res_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MULC_IDLE;
      op_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      if (accept) begin
        op_q <= bus.in_op;
        src1_q <= bus.in_src1;
        src2_q <= bus.in_src2;
      end
    end
  end
  // raw sources are kept as the cache key; MULW operands are derived from them as signed 32-bit values
  ysyx_22041752_mul_rcache #(.XLEN(XLEN)) u_rcache (
    .clk       (clk),
    .reset     (reset),
    .lk_op_i   (bus.in_op),
    .lk_src1_i (bus.in_src1),
    .lk_src2_i (bus.in_src2),
    .lk_hit_o  (lk_hit),
    .lk_data_o (lk_data),
    .wr_en_i   (done && CACHE_EN),
    .wr_op_i   (op_q),
    .wr_src1_i (src1_q),
    .wr_src2_i (src2_q),
    .wr_data_i (product)
  );
  assign bus.in_ready = state_q == MULC_IDLE;
  assign bus.out_valid = state_q == MULC_DONE;
  assign bus.out_result = res_q;
  assign bus.mul_valid = state_q == MULC_BUSY;
  assign bus.mul_u = mode.u;
  assign bus.mul_su = mode.su;
  assign bus.mul_h = mode.h;
  assign bus.mul_multiplicand = mode.w ? sext32(src1_q) : src1_q;
  assign bus.mul_multiplier = mode.w ? sext32(src2_q) : src2_q;
endmodule

// File: tb/tb_ysyx_22041752_mul_ctrl.sv
// tb_ysyx_22041752_mul_ctrl: vector table, random ops against a reference model, and flush/reset/backpressure sequences
module tb_ysyx_22041752_mul_ctrl;
  import ysyx_22041752_mul_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ysyx_22041752_mul_ctrl_if bus ();
  ysyx_22041752_mul_ctrl #(.CACHE_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  int cnt;
  logic [127:0] ea, eb, ep;
  always_comb begin
    ea = bus.mul_u ? {64'b0, bus.mul_multiplicand} : {{64{bus.mul_multiplicand[63]}}, bus.mul_multiplicand};
    eb = (bus.mul_u || bus.mul_su) ? {64'b0, bus.mul_multiplier} : {{64{bus.mul_multiplier[63]}}, bus.mul_multiplier};
    ep = ea * eb;
  end
  assign bus.mul_product = bus.mul_h ? ep[127:64] : ep[63:0];
  assign bus.mul_out_valid = bus.mul_valid && (cnt == 65 || bus.mul_multiplicand == 0 || bus.mul_multiplier == 0);
  always_ff @(posedge clk) cnt <= (!bus.mul_valid || bus.flush) ? 0 : cnt + 1;
  int n_pass = 0;
  int n_tot = 0;
  bit mc_vld = 1'b0;
  logic [2:0] mc_op;
  logic [63:0] mc_a, mc_b;
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    logic [63:0] lo;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    za = {64'b0, a};
    zb = {64'b0, b};
    lo = a * b;
    case (op)
      3'd1: p = sa * sb;
      3'd2: p = sa * zb;
      3'd3: p = za * zb;
      default: p = 128'b0;
    endcase
    if (op == 3'd4) return {{32{lo[31]}}, lo[31:0]};
    if (op >= 3'd1 && op <= 3'd3) return p[127:64];
    return lo;
  endfunction
  function automatic int model_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bit zero;
    if (mc_vld && mc_op == op && mc_a == a && mc_b == b) return 1;
    zero = (op == 3'd4) ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0);
    return zero ? 2 : 67;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold,
                       output int lat, output int mv, output logic [63:0] res, output bit stable);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_src1 = a;
    bus.in_src2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op = 3'($urandom);
    bus.in_src1 = {$urandom, $urandom};
    bus.in_src2 = {$urandom, $urandom};
    lat = 1;
    mv = 0;
    while (!bus.out_valid && lat < 300) begin
      mv += int'(bus.mul_valid);
      @(negedge clk);
      lat++;
    end
    res = bus.out_result;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_result !== res || bus.in_ready) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic run_check(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input int hold);
    int lat, mv;
    logic [63:0] res;
    bit stable;
    do_op(op, a, b, hold, lat, mv, res, stable);
    chk({name, ".res"}, res, exp_res);
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({name, ".mulv"}, 64'(mv), 64'(exp_lat == 1 ? 0 : exp_lat - 1));
    if (hold > 0) chk({name, ".hold"}, 64'(stable), 64'd1);
    if (lat < 300) begin
      mc_vld = 1'b1;
      mc_op = op;
      mc_a = a;
      mc_b = b;
    end
  endtask
  typedef struct {
    logic [2:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int lat;
  } vec_t;
  vec_t v[13];
  initial begin
    logic [2:0] op, pop;
    logic [63:0] a, b, pa, pb;
    int r;
    bit have = 1'b0;
    v[0] = '{3'd0, 64'd3, 64'd5, 64'd15, 67};
    v[1] = '{3'd0, 64'd3, 64'd5, 64'd15, 1};
    v[2] = '{3'd0, 64'd3, 64'd6, 64'd18, 67};
    v[3] = '{3'd0, 64'd3, 64'd5, 64'd15, 67};
    v[4] = '{3'd1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[5] = '{3'd3, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 67};
    v[6] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[7] = '{3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 67};
    v[8] = '{3'd0, 64'd0, 64'd9, 64'd0, 2};
    v[9] = '{3'd7, 64'd4, 64'd5, 64'd20, 67};
    v[10] = '{3'd4, 64'hFFFF_FFFF_0000_0003, 64'h1234_5678_0000_0005, 64'd15, 67};
    v[11] = '{3'd4, 64'h0000_0001_0000_0000, 64'd5, 64'd0, 2};
    v[12] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 3'd0;
    bus.in_src1 = '0;
    bus.in_src2 = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.flags", 64'({bus.in_ready, bus.out_valid, bus.mul_valid, bus.mul_u, bus.mul_su, bus.mul_h}), 64'b100000);
    chk("reset.result", bus.out_result, 64'd0);
    chk("reset.mcand", bus.mul_multiplicand | bus.mul_multiplier, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 13; i++)
      run_check($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].res, v[i].lat, 0);
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2 && have) begin
        op = pop;
        a = pa;
        b = pb;
      end else begin
        op = 3'($urandom_range(0, 7));
        a = (r == 2) ? 64'd0 : (r == 4) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
        b = (r == 3) ? 64'd0 : (r == 4) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      end
      pop = op;
      pa = a;
      pb = b;
      have = 1'b1;
      run_check($sformatf("rnd%0d", i), op, a, b, ref_mul(op, a, b), model_lat(op, a, b), $urandom_range(0, 3));
    end
    run_check("bp", 3'd0, 64'hAB, 64'h10, 64'hAB0, model_lat(3'd0, 64'hAB, 64'h10), 10);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd0;
    bus.in_src1 = 64'd1234;
    bus.in_src2 = 64'd5678;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush30.state", 64'({bus.mul_valid, bus.out_valid, bus.in_ready}), 64'b001);
    run_check("after_flush", 3'd0, 64'd7, 64'd7, 64'd49, model_lat(3'd0, 64'd7, 64'd7), 0);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd0;
    bus.in_src1 = 64'd0;
    bus.in_src2 = 64'd4;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("flushdone.mov", 64'(bus.mul_out_valid), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flushdone.state", 64'({bus.mul_valid, bus.out_valid, bus.in_ready}), 64'b001);
    run_check("flushdone.miss", 3'd0, 64'd0, 64'd4, 64'd0, model_lat(3'd0, 64'd0, 64'd4), 0);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd0;
    bus.in_src1 = 64'd2;
    bus.in_src2 = 64'd2;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flushidle.state", 64'({bus.in_ready, bus.mul_valid, bus.out_valid}), 64'b100);
    run_check("pre_rst", 3'd0, 64'd9, 64'd9, 64'd81, model_lat(3'd0, 64'd9, 64'd9), 0);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd3;
    bus.in_src1 = 64'd3;
    bus.in_src2 = 64'd5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("rstbusy.pre", 64'({bus.mul_valid, bus.mul_u}), 64'b11);
    reset = 1'b1;
    #1;
    chk("rstbusy.flags", 64'({bus.in_ready, bus.out_valid, bus.mul_valid, bus.mul_u, bus.mul_su, bus.mul_h}), 64'b100000);
    chk("rstbusy.result", bus.out_result, 64'd0);
    chk("rstbusy.mcand", bus.mul_multiplicand | bus.mul_multiplier, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mc_vld = 1'b0;
    @(negedge clk);
    run_check("post_rst", 3'd0, 64'd9, 64'd9, 64'd81, 67, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
